grant_tx_serializer: RTL and testbench
======================================

// Module: grant_tx_serializer
// PURPOSE
//   Downstream stage of the request priority selector. When any request is
//   pending, captures the selector's grant index and selected data word.
//   Returns a one-cycle one-hot ack to the winning source, then serialises
//   one frame on a single tx line at a fixed bit period.
//   Frame order: start bit, source ID, data, even parity, stop bit.
// PARAMETERS
//   NUM_INPUTS    4   number of sources; must be >= 2 (matches selector)
//   DATA_WIDTH    8   data word width; must be >= 1
//   CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 2
//   localparam ID_W = $clog2(NUM_INPUTS); FRAME_BITS = ID_W+DATA_WIDTH+3
// PORTS
//   clk         in   1           single clock, all logic on rising edge
//   rst         in   1           synchronous reset, active-high
//   req         in   NUM_INPUTS  raw source request vector (same as selector's)
//   grant       in   ID_W        selector's granted index
//   data_in     in   DATA_WIDTH  selector's data_out
//   ack         out  NUM_INPUTS  one-hot, 1-cycle: frame accepted from source
//   tx          out  1           serial output, idle high
//   busy        out  1           high from capture through end of stop bit
//   frame_done  out  1           1-cycle pulse after stop bit completes
// BEHAVIOUR
//   Reset: tx=1, ack=0, busy=0, frame_done=0, state=IDLE, counters=0.
//     Reset mid-frame abandons the frame; outputs take reset values next edge.
//   FSM states: IDLE -> START -> ID -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE capture: edge where |req && grant < NUM_INPUTS.
//     Registers grant into id_q and data_in into data_q.
//     Next cycle: ack = 1 << grant, state = START, tx = 0, busy = 1.
//     If grant >= NUM_INPUTS, no capture and no ack; remains IDLE.
//   ack is high only in the first START cycle; sources drop or advance req
//     on seeing it. req/grant/data_in are ignored outside IDLE.
//   Each bit is held exactly CLKS_PER_BIT cycles.
//     Baud counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
//     Bit index counter is sized for max(ID_W, DATA_WIDTH).
//   ID: id_q, ID_W bits, LSB first. DATA: data_q, LSB first.
//   PARITY: ^{id_q, data_q}; ones count over ID+data+parity is even.
//   STOP: tx = 1 for CLKS_PER_BIT cycles.
//     Then state = IDLE and frame_done = 1 for that IDLE cycle; busy = 0.
//   Latency: capture edge -> tx falls 1 cycle later.
//     Frame lasts FRAME_BITS*CLKS_PER_BIT cycles.
//     frame_done asserts FRAME_BITS*CLKS_PER_BIT+1 cycles after capture edge.
//   Back-to-back: if req is pending in the frame_done cycle, the next capture
//     happens on that edge. Minimum gap between frames = 1 cycle of tx high
//     beyond the stop bit.
//   Simultaneous rst and req: rst wins, no capture, no ack.
//   busy and ack are registered outputs; tx is a registered output (no glitches).
// TESTING  (NUM_INPUTS=4, DATA_WIDTH=8, CLKS_PER_BIT=4 => FRAME_BITS=13, 52 cycles)
//   1. Hold rst 3 cycles with req=4'b1111 -> tx=1, ack=0, busy=0,
//      frame_done=0 throughout; no capture on the release edge.
//   2. req=4'b0100, grant=2, data_in=8'hA5 -> ack=4'b0100 for 1 cycle.
//      tx bits: 0 | 0,1 | 1,0,1,0,0,1,0,1 | 1 | 1, each bit held 4 cycles.
//      frame_done 53 cycles after capture.
//   3. req=4'b0001, grant=0, data_in=8'h00 -> ID bits 0,0, data all 0,
//      parity 0, stop 1; busy high for exactly 52 cycles.
//   4. Mid-frame, change req/grant/data_in randomly -> no ack pulses,
//      transmitted bits unchanged.
//   5. Keep req asserted with new grant/data after each ack -> second
//      frame's start bit begins in the cycle after frame_done; IDs/data match.
//   6. Assert rst during DATA bit 3 -> next cycle tx=1, busy=0, ack=0.
//      A subsequent req sends a complete, correct fresh frame.

Source files
------------

// File: rtl/grant_tx_serializer.sv
// grant_tx_serializer: captures granted id/data, acks the source, then sends start|id|data|parity|stop on tx
module grant_tx_serializer #(
  parameter int NUM_INPUTS   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  localparam int ID_W = $clog2(NUM_INPUTS),
  localparam int FRAME_BITS = ID_W + DATA_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [ID_W-1:0]       grant,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [NUM_INPUTS-1:0] ack,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int MAXW = ID_W > DATA_WIDTH ? ID_W : DATA_WIDTH;
  localparam int IW = MAXW > 1 ? $clog2(MAXW) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, ID, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [ID_W-1:0] id_q, id_sh;
  logic [DATA_WIDTH-1:0] data_q, data_sh;
  logic [NUM_INPUTS-1:0] ack_n;
  logic last, load, id_end, data_end, tx_n;
  always_comb begin
    last = cnt == CW'(CLKS_PER_BIT - 1);
    load = state == IDLE && |req && int'(grant) < NUM_INPUTS;
    id_end = idx == IW'(ID_W - 1);
    data_end = idx == IW'(DATA_WIDTH - 1);
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        state_n = load ? START : IDLE;
      end
      START: state_n = last ? ID : START;
      ID: if (last) begin
        idx_n = id_end ? '0 : idx + 1'b1;
        state_n = id_end ? DATA : ID;
      end
      DATA: if (last) begin
        idx_n = data_end ? '0 : idx + 1'b1;
        state_n = data_end ? PARITY : DATA;
      end
      PARITY: state_n = last ? STOP : PARITY;
      STOP: state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    ack_n = load ? NUM_INPUTS'(1) << grant : '0;
    id_sh = id_q >> idx_n;
    data_sh = data_q >> idx_n;
    tx_n = state_n == START ? 1'b0 :
           state_n == ID ? id_sh[0] :
           state_n == DATA ? data_sh[0] :
           state_n == PARITY ? ^{id_q, data_q} : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      id_q <= '0;
      data_q <= '0;
      ack <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      if (load) begin
        id_q <= grant;
        data_q <= data_in;
      end
      ack <= ack_n;
      tx <= tx_n;
      busy <= state_n != IDLE;
      frame_done <= state == STOP && last;
    end
  end
endmodule

// File: tb/tb_grant_tx_serializer.sv
// tb_grant_tx_serializer: scoreboard bench for grant_tx_serializer with 4 sources, 8-bit data, 4 clks per bit
module tb_grant_tx_serializer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [1:0] grant;
  logic [7:0] data_in;
  logic [3:0] ack;
  logic tx, busy, frame_done;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = -100;
  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic b2b;
  } frame_t;
  frame_t q[$];
  grant_tx_serializer #(.NUM_INPUTS(4), .DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .data_in(data_in),
    .ack(ack), .tx(tx), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] id, input logic [7:0] d, input logic b2b);
    frame_t f;
    f.id = id;
    f.data = d;
    f.b2b = b2b;
    q.push_back(f);
  endtask
  task automatic run_frame(input frame_t e);
    logic [12:0] fb;
    logic [3:0] ea;
    fb = {1'b1, ^{e.id, e.data}, e.data, e.id, 1'b0};
    ea = 4'b0001 << e.id;
    if (e.b2b) chk("b2b_gap", cyc, last_done + 1);
    for (int k = 0; k < 52; k++) begin
      if (k > 0) @(negedge clk);
      if (rst) return;
      chk($sformatf("frame id%0d bit%0d", e.id, k / 4), {tx, busy, frame_done, ack},
          {fb[k/4], 1'b1, 1'b0, k == 0 ? ea : 4'b0000});
    end
    @(negedge clk);
    chk("frame_done", {tx, busy, frame_done, ack}, {1'b1, 1'b0, 1'b1, 4'b0000});
    last_done = cyc;
  endtask
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        if (q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
        else run_frame(q.pop_front());
      end else chk("idle", {tx, busy, frame_done, ack}, {1'b1, 1'b0, 1'b0, 4'b0000});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    req = 4'b1111;
    grant = 2'd1;
    data_in = 8'h55;
    tick(3);
    rst = 1'b0;
    req = 4'b0000;
    tick(4);
    req = 4'b0100; grant = 2'd2; data_in = 8'hA5;
    push(2'd2, 8'hA5, 1'b0);
    tick(1);
    req = 4'b0000;
    tick(60);
    req = 4'b0001; grant = 2'd0; data_in = 8'h00;
    push(2'd0, 8'h00, 1'b0);
    tick(1);
    req = 4'b0000;
    tick(60);
    req = 4'b0010; grant = 2'd1; data_in = 8'h5A;
    push(2'd1, 8'h5A, 1'b0);
    tick(1);
    repeat (44) begin
      req = 4'($urandom);
      grant = 2'($urandom);
      data_in = 8'($urandom);
      tick(1);
    end
    req = 4'b0000;
    tick(15);
    req = 4'b0010; grant = 2'd1; data_in = 8'h3C;
    push(2'd1, 8'h3C, 1'b0);
    tick(1);
    grant = 2'd3; data_in = 8'hC3;
    push(2'd3, 8'hC3, 1'b1);
    tick(53);
    req = 4'b0000;
    tick(60);
    req = 4'b0010; grant = 2'd1; data_in = 8'hF0;
    push(2'd1, 8'hF0, 1'b0);
    tick(1);
    req = 4'b0000;
    tick(24);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_frame", {tx, busy, ack}, {1'b1, 1'b0, 4'b0000});
    rst = 1'b0;
    tick(5);
    req = 4'b1000; grant = 2'd3; data_in = 8'h96;
    push(2'd3, 8'h96, 1'b0);
    tick(1);
    req = 4'b0000;
    tick(60);
    chk("frames_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
